// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution MAC processing element.
// Helpers work on a fixed wide signed type so any accumulator width up to WIDE_W-1 fits.
package conv_pkg;

    localparam int WIDE_W = 128;

    typedef struct packed {
        logic first;
        logic last;
        logic relu;
    } beat_tag_t;

    function automatic int tree_depth(input int n);
        int d;
        d = 0;
        for (int p = 1; p < n; p = p * 2) d++;
        return d;
    endfunction

    // Number of nodes on level l of a pairwise reduction of n operands.
    function automatic int node_cnt(input int n, input int l);
        int c;
        c = n;
        for (int i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // Flat index of the first node of level l (levels 1 and up are stored).
    function automatic int level_off(input int n, input int l);
        int o;
        o = 0;
        for (int j = 1; j < l; j++) o += node_cnt(n, j);
        return o;
    endfunction

    function automatic logic signed [WIDE_W-1:0] round_shift(
        input logic signed [WIDE_W-1:0] v,
        input int                       sh
    );
        logic signed [WIDE_W-1:0] one_w;
        one_w = WIDE_W'(1);
        if (sh == 0) return v;
        return (v + (one_w <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_max(input int out_w);
        logic signed [WIDE_W-1:0] one_w;
        one_w = WIDE_W'(1);
        return (one_w <<< (out_w - 1)) - one_w;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_clip(
        input logic signed [WIDE_W-1:0] v,
        input int                       out_w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = sat_max(out_w);
        lo = -hi - WIDE_W'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic sat_hit(
        input logic signed [WIDE_W-1:0] v,
        input int                       out_w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = sat_max(out_w);
        lo = -hi - WIDE_W'(1);
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Fully pipelined pairwise adder tree: N signed W-bit operands, one registered level per halving.
// An odd leftover operand on a level is carried forward through a register so all paths align.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int N = 9,
    parameter int W = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [N*W-1:0]      data_in,
    output logic                valid_out,
    output logic signed [W-1:0] sum_out,
    output logic                busy
);

    localparam int DEPTH = tree_depth(N);

    if (DEPTH == 0) begin : g_flat
        assign sum_out   = $signed(data_in[W-1:0]);
        assign valid_out = valid_in;
        assign busy      = 1'b0;
    end else begin : g_tree
        localparam int TOTAL = level_off(N, DEPTH + 1);

        logic signed [W-1:0] node [TOTAL];
        logic [DEPTH-1:0]    vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else begin
                vld[0] <= valid_in;
                for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
            end
        end

        for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
            localparam int CNT  = node_cnt(N, l);
            localparam int PCNT = node_cnt(N, l - 1);
            localparam int OFF  = level_off(N, l);
            localparam int POFF = level_off(N, l - 1);

            logic en;
            if (l == 1) begin : g_en_in
                assign en = valid_in;
            end else begin : g_en_lvl
                assign en = vld[l-2];
            end

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (l == 1 && 2*i+1 < PCNT) begin : g_leaf_sum
                    always_ff @(posedge clk)
                        if (en) node[OFF+i] <= $signed(data_in[2*i*W +: W])
                                             + $signed(data_in[(2*i+1)*W +: W]);
                end else if (l == 1) begin : g_leaf_pass
                    always_ff @(posedge clk)
                        if (en) node[OFF+i] <= $signed(data_in[2*i*W +: W]);
                end else if (2*i+1 < PCNT) begin : g_sum
                    always_ff @(posedge clk)
                        if (en) node[OFF+i] <= node[POFF+2*i] + node[POFF+2*i+1];
                end else begin : g_pass
                    always_ff @(posedge clk)
                        if (en) node[OFF+i] <= node[POFF+2*i];
                end
            end
        end

        assign sum_out   = node[TOTAL-1];
        assign valid_out = vld[DEPTH-1];
        assign busy      = |vld;
    end

endmodule

// File: rtl/conv_mac_pe.sv
// KxK fixed-point convolution PE: multiply, adder tree, per-pixel channel accumulation,
// then bias, half-up rounding shift, optional ReLU and saturation to OUT_W.
module conv_mac_pe
    import conv_pkg::*;
#(
    parameter int K          = 3,
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 16,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 16,
    parameter int IN_CH      = 32,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [K*K*DATA_W-1:0]     data_in,
    input  logic [K*K*WEIGHT_W-1:0]   weight_in,
    input  logic signed [ACC_W-1:0]   bias,
    input  logic                      relu_en,
    output logic                      valid_out,
    output logic signed [OUT_W-1:0]   data_out,
    output logic                      sat_out,
    output logic                      busy
);

    localparam int TAPS   = K * K;
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int T      = tree_depth(TAPS);
    localparam int CNT_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(IN_CH - 1);

    logic [CNT_W-1:0] chan_cnt;
    logic             ch_first;
    logic             ch_last;

    assign ch_first = (chan_cnt == '0);
    assign ch_last  = (chan_cnt == LAST_CH);

    // S0: products plus the side-band that must stay aligned with them
    logic                      s0_valid;
    logic signed [PROD_W-1:0]  prod_q    [TAPS];
    beat_tag_t                 tag_pipe  [T+1];
    logic signed [ACC_W-1:0]   bias_pipe [T+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            chan_cnt <= '0;
        end else begin
            s0_valid <= valid_in;
            if (valid_in) chan_cnt <= ch_last ? '0 : chan_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int i = 0; i < TAPS; i++)
                prod_q[i] <= $signed(data_in[i*DATA_W +: DATA_W])
                           * $signed(weight_in[i*WEIGHT_W +: WEIGHT_W]);
            tag_pipe[0]  <= '{first: ch_first, last: ch_last, relu: relu_en};
            bias_pipe[0] <= bias;
        end
        for (int i = 1; i <= T; i++) begin
            tag_pipe[i]  <= tag_pipe[i-1];
            bias_pipe[i] <= bias_pipe[i-1];
        end
    end

    logic [TAPS*ACC_W-1:0]    tree_in;
    logic                     tree_valid;
    logic signed [ACC_W-1:0]  tree_sum;
    logic                     tree_busy;

    always_comb begin
        tree_in = '0;
        for (int i = 0; i < TAPS; i++)
            tree_in[i*ACC_W +: ACC_W] = {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end

    conv_adder_tree #(
        .N (TAPS),
        .W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (s0_valid),
        .data_in   (tree_in),
        .valid_out (tree_valid),
        .sum_out   (tree_sum),
        .busy      (tree_busy)
    );

    // SA: first beat of a pixel restarts the sum, last beat folds in the bias
    logic                     acc_done;
    logic                     acc_relu;
    logic signed [ACC_W-1:0]  acc;
    beat_tag_t                tag_t;
    logic signed [ACC_W-1:0]  bias_t;

    assign tag_t  = tag_pipe[T];
    assign bias_t = bias_pipe[T];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            acc_done <= 1'b0;
            acc_relu <= 1'b0;
        end else begin
            acc_done <= tree_valid & tag_t.last;
            if (tree_valid) begin
                acc      <= (tag_t.first ? '0 : acc) + tree_sum + (tag_t.last ? bias_t : '0);
                acc_relu <= tag_t.relu;
            end
        end
    end

    // SO: ReLU runs before the clamp, so zeroing a negative never counts as saturation
    logic signed [WIDE_W-1:0] acc_wide;
    logic signed [WIDE_W-1:0] post_val;

    always_comb begin
        acc_wide = {{(WIDE_W-ACC_W){acc[ACC_W-1]}}, acc};
        post_val = round_shift(acc_wide, FRAC_SHIFT);
        if (acc_relu && post_val[WIDE_W-1]) post_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sat_out   <= 1'b0;
        end else begin
            valid_out <= acc_done;
            sat_out   <= acc_done & sat_hit(post_val, OUT_W);
            if (acc_done) data_out <= OUT_W'(sat_clip(post_val, OUT_W));
        end
    end

    assign busy = s0_valid | tree_busy | acc_done | (chan_cnt != '0);

endmodule

// File: tb/tb_conv_mac_pe.sv
// Directed bench for conv_mac_pe: three instances (IN_CH=1/shift 0, IN_CH=4/shift 0, IN_CH=1/shift 8)
// share stimulus buses; each instance has its own valid_in so only the targeted one sees beats.
module tb_conv_mac_pe;

    logic               clk;
    logic               rst;
    logic [2:0]         valid_in;
    logic [143:0]       data_in;
    logic [143:0]       weight_in;
    logic [39:0]        bias;
    logic               relu_en;
    logic [2:0]         vo;
    logic [2:0][15:0]   dout;
    logic [2:0]         sat;
    logic [2:0]         busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          pulses   [3];
    logic [15:0] last_d   [3];
    logic        last_s   [3];
    int          last_cyc [3];
    logic [15:0] qd0 [$];
    int          qc0 [$];
    logic [15:0] qd1 [$];
    int          qc1 [$];

    conv_mac_pe #(.K(3), .DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .OUT_W(16), .IN_CH(1), .FRAC_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in[0]), .data_in(data_in), .weight_in(weight_in),
        .bias(bias), .relu_en(relu_en), .valid_out(vo[0]), .data_out(dout[0]), .sat_out(sat[0]), .busy(busy[0]));

    conv_mac_pe #(.K(3), .DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .OUT_W(16), .IN_CH(4), .FRAC_SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in[1]), .data_in(data_in), .weight_in(weight_in),
        .bias(bias), .relu_en(relu_en), .valid_out(vo[1]), .data_out(dout[1]), .sat_out(sat[1]), .busy(busy[1]));

    conv_mac_pe #(.K(3), .DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .OUT_W(16), .IN_CH(1), .FRAC_SHIFT(8)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in[2]), .data_in(data_in), .weight_in(weight_in),
        .bias(bias), .relu_en(relu_en), .valid_out(vo[2]), .data_out(dout[2]), .sat_out(sat[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and log any output pulses seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (vo[i]) begin
                pulses[i]++;
                last_d[i]   = dout[i];
                last_s[i]   = sat[i];
                last_cyc[i] = cyc;
            end
        end
        if (vo[0]) begin qd0.push_back(dout[0]); qc0.push_back(cyc); end
        if (vo[1]) begin qd1.push_back(dout[1]); qc1.push_back(cyc); end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0; last_d[i] = '0; last_s[i] = 1'b0; last_cyc[i] = 0;
        end
        qd0.delete(); qc0.delete(); qd1.delete(); qc1.delete();
    endtask

    task automatic beat(input int which, input int tap, input int d, input int w, input longint b, input bit r);
        tick();
        data_in   = '0;
        weight_in = '0;
        data_in[tap*16 +: 16]   = 16'(d);
        weight_in[tap*16 +: 16] = 16'(w);
        bias     = 40'(b);
        relu_en  = r;
        valid_in = '0;
        valid_in[which] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            valid_in = '0;
        end
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        valid_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (vo[i] !== 1'b0) begin fails++; $display("FAIL reset_valid dut%0d: got %0b expected 0", i, vo[i]); end
            tests++; if (dout[i] !== 16'd0) begin fails++; $display("FAIL reset_data dut%0d: got %0d expected 0", i, $signed(dout[i])); end
            tests++; if (sat[i] !== 1'b0) begin fails++; $display("FAIL reset_sat dut%0d: got %0b expected 0", i, sat[i]); end
            tests++; if (busy[i] !== 1'b0) begin fails++; $display("FAIL reset_busy dut%0d: got %0b expected 0", i, busy[i]); end
        end
    endtask

    task automatic test_single();
        int c0;
        clear_mon();
        tick();
        for (int t = 0; t < 9; t++) begin
            data_in[t*16 +: 16]   = 16'd1;
            weight_in[t*16 +: 16] = 16'd2;
        end
        bias = 40'd5;
        relu_en = 1'b0;
        valid_in = 3'b001;
        c0 = cyc;
        idle(12);
        tests++; if (pulses[0] !== 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", pulses[0]); end
        tests++; if (last_d[0] !== 16'd23) begin fails++; $display("FAIL single_data: got %0d expected 23", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b0) begin fails++; $display("FAIL single_sat: got %0b expected 0", last_s[0]); end
        tests++; if (last_cyc[0] - c0 !== 7) begin fails++; $display("FAIL single_latency: got %0d expected 7", last_cyc[0] - c0); end
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %0b expected 0", busy[0]); end
    endtask

    task automatic test_channels();
        clear_mon();
        beat(1, 0, 10, 1, 999, 1);
        beat(1, 4, -3, 1, 999, 1);
        idle(2);
        beat(1, 8, 7, 1, 999, 0);
        idle(3);
        tests++; if (busy[1] !== 1'b1) begin fails++; $display("FAIL chan_busy_partial: got %0b expected 1", busy[1]); end
        tests++; if (pulses[1] !== 0) begin fails++; $display("FAIL chan_early_pulse: got %0d expected 0", pulses[1]); end
        idle(2);
        beat(1, 2, 1, 1, -5, 0);
        idle(12);
        tests++; if (pulses[1] !== 1) begin fails++; $display("FAIL chan_pulses: got %0d expected 1", pulses[1]); end
        tests++; if (last_d[1] !== 16'd10) begin fails++; $display("FAIL chan_data: got %0d expected 10", $signed(last_d[1])); end
        tests++; if (last_s[1] !== 1'b0) begin fails++; $display("FAIL chan_sat: got %0b expected 0", last_s[1]); end
        tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL chan_busy_done: got %0b expected 0", busy[1]); end
    endtask

    task automatic test_saturation();
        clear_mon();
        beat(0, 3, 20000, 2, 0, 0); idle(10);
        tests++; if (last_d[0] !== 16'd32767) begin fails++; $display("FAIL sat_pos_data: got %0d expected 32767", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b1) begin fails++; $display("FAIL sat_pos_flag: got %0b expected 1", last_s[0]); end
        beat(0, 5, -20000, 2, 0, 0); idle(10);
        tests++; if (last_d[0] !== 16'h8000) begin fails++; $display("FAIL sat_neg_data: got %0d expected -32768", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b1) begin fails++; $display("FAIL sat_neg_flag: got %0b expected 1", last_s[0]); end
        beat(0, 1, 32767, 1, 0, 0); idle(10);
        tests++; if (last_d[0] !== 16'd32767) begin fails++; $display("FAIL sat_edge_data: got %0d expected 32767", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b0) begin fails++; $display("FAIL sat_edge_flag: got %0b expected 0", last_s[0]); end
        beat(0, 0, 32767, 1, 1, 0); idle(10);
        tests++; if (last_d[0] !== 16'd32767) begin fails++; $display("FAIL sat_bias_data: got %0d expected 32767", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b1) begin fails++; $display("FAIL sat_bias_flag: got %0b expected 1", last_s[0]); end
        tests++; if (pulses[0] !== 4) begin fails++; $display("FAIL sat_pulses: got %0d expected 4", pulses[0]); end
    endtask

    task automatic test_relu();
        clear_mon();
        beat(0, 6, -17, 1, 0, 1); idle(10);
        tests++; if (last_d[0] !== 16'd0) begin fails++; $display("FAIL relu_on_data: got %0d expected 0", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b0) begin fails++; $display("FAIL relu_on_sat: got %0b expected 0", last_s[0]); end
        beat(0, 6, -17, 1, 0, 0); idle(10);
        tests++; if (last_d[0] !== 16'hFFEF) begin fails++; $display("FAIL relu_off_data: got %0d expected -17", $signed(last_d[0])); end
        beat(0, 7, -20000, 2, 0, 1); idle(10);
        tests++; if (last_d[0] !== 16'd0) begin fails++; $display("FAIL relu_big_data: got %0d expected 0", $signed(last_d[0])); end
        tests++; if (last_s[0] !== 1'b0) begin fails++; $display("FAIL relu_big_sat: got %0b expected 0", last_s[0]); end
        beat(0, 2, 9, 1, 0, 1); idle(10);
        tests++; if (last_d[0] !== 16'd9) begin fails++; $display("FAIL relu_pos_data: got %0d expected 9", $signed(last_d[0])); end
    endtask

    task automatic test_round();
        clear_mon();
        beat(2, 0, 384, 1, 0, 0); idle(10);
        tests++; if (last_d[2] !== 16'd2) begin fails++; $display("FAIL round_p384: got %0d expected 2", $signed(last_d[2])); end
        beat(2, 3, -384, 1, 0, 0); idle(10);
        tests++; if (last_d[2] !== 16'hFFFF) begin fails++; $display("FAIL round_m384: got %0d expected -1", $signed(last_d[2])); end
        beat(2, 4, 383, 1, 0, 0); idle(10);
        tests++; if (last_d[2] !== 16'd1) begin fails++; $display("FAIL round_p383: got %0d expected 1", $signed(last_d[2])); end
        beat(2, 8, -385, 1, 0, 0); idle(10);
        tests++; if (last_d[2] !== 16'hFFFE) begin fails++; $display("FAIL round_m385: got %0d expected -2", $signed(last_d[2])); end
        tests++; if (pulses[2] !== 4) begin fails++; $display("FAIL round_pulses: got %0d expected 4", pulses[2]); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        beat(0, 0, 5, 1, 0, 0);
        beat(0, 1, 6, 1, 0, 0);
        beat(0, 2, 7, 1, 0, 0);
        idle(10);
        tests++;
        if (qd0.size() !== 3) begin
            fails++; $display("FAIL b2b1_count: got %0d expected 3", qd0.size());
        end else begin
            tests++; if (qd0[0] !== 16'd5) begin fails++; $display("FAIL b2b1_d0: got %0d expected 5", $signed(qd0[0])); end
            tests++; if (qd0[1] !== 16'd6) begin fails++; $display("FAIL b2b1_d1: got %0d expected 6", $signed(qd0[1])); end
            tests++; if (qd0[2] !== 16'd7) begin fails++; $display("FAIL b2b1_d2: got %0d expected 7", $signed(qd0[2])); end
            tests++; if (qc0[2] - qc0[0] !== 2) begin fails++; $display("FAIL b2b1_spacing: got %0d expected 2", qc0[2] - qc0[0]); end
        end
        beat(1, 0, 1, 1, 777, 0);
        beat(1, 1, 2, 1, 777, 0);
        beat(1, 2, 3, 1, 777, 0);
        beat(1, 3, 4, 1, 0, 0);
        beat(1, 4, 5, 1, 777, 0);
        beat(1, 5, 5, 1, 777, 0);
        beat(1, 6, 5, 1, 777, 0);
        beat(1, 7, 5, 1, 1, 0);
        idle(12);
        tests++;
        if (qd1.size() !== 2) begin
            fails++; $display("FAIL b2b4_count: got %0d expected 2", qd1.size());
        end else begin
            tests++; if (qd1[0] !== 16'd10) begin fails++; $display("FAIL b2b4_d0: got %0d expected 10", $signed(qd1[0])); end
            tests++; if (qd1[1] !== 16'd21) begin fails++; $display("FAIL b2b4_d1: got %0d expected 21", $signed(qd1[1])); end
            tests++; if (qc1[1] - qc1[0] !== 4) begin fails++; $display("FAIL b2b4_spacing: got %0d expected 4", qc1[1] - qc1[0]); end
        end
    endtask

    task automatic test_reset_mid_pixel();
        clear_mon();
        beat(1, 0, 100, 1, 0, 0);
        beat(1, 1, 100, 1, 0, 0);
        tick();
        valid_in = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b expected 0", busy[1]); end
        beat(1, 0, 1, 1, 0, 0);
        beat(1, 1, 2, 1, 0, 0);
        beat(1, 2, 3, 1, 0, 0);
        beat(1, 3, 4, 1, 0, 0);
        idle(15);
        tests++; if (pulses[1] !== 1) begin fails++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses[1]); end
        tests++; if (last_d[1] !== 16'd10) begin fails++; $display("FAIL rstmid_data: got %0d expected 10", $signed(last_d[1])); end
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = '0;
        data_in   = '0;
        weight_in = '0;
        bias      = '0;
        relu_en   = 1'b0;
        clear_mon();
        test_reset();
        test_single();
        test_channels();
        test_saturation();
        test_relu();
        test_round();
        test_back_to_back();
        test_reset_mid_pixel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
